// File: rtl/arb_requester_4.sv
`default_nettype none
// ============================================================================
// Module   : arb_requester_4
// Purpose  : Requester-side front end for a 4-way round-robin arbiter.
//            Each of four source ports fills a private FIFO; req[i] is held
//            while FIFO i is non-empty, and every legal grant pops the
//            granted FIFO head onto a single registered output. Illegal
//            grants (multi-hot, or one-hot to a non-requesting port) set a
//            sticky error flag.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_data    - per-port push strobe and data
//            in_ready            - per-port FIFO not full (0 during reset)
//            req                 - request vector to arbiter (0 during reset)
//            gnt/valid           - grant vector and its qualifier
//            out_valid/out_port/out_data - popped word, 1-cycle latency
//            gnt_err             - sticky grant protocol error
// Revision : 1.0 - initial release
// ============================================================================
module arb_requester_4 #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic [3:0]      req,
    input  logic [3:0]      gnt,
    input  logic            valid,
    output logic            out_valid,
    output logic [1:0]      out_port,
    output logic [DW-1:0]   out_data,
    output logic            gnt_err
);

    localparam int unsigned       c_CW   = $clog2(DEPTH + 1);
    localparam int unsigned       c_PW   = $clog2(DEPTH);
    localparam logic [c_CW-1:0]   c_FULL = c_CW'(DEPTH);

    logic [3:0]      w_not_full;
    logic [3:0]      w_has_data;
    logic [4*DW-1:0] w_head;

    logic            w_multi;
    logic            w_onehot;
    logic            w_hit;
    logic            w_grant_ok;
    logic            w_bad;
    logic [1:0]      w_idx;
    logic [DW-1:0]   w_sel_data;

    logic            r_out_valid_q, w_out_valid_d;
    logic [1:0]      r_out_port_q,  w_out_port_d;
    logic [DW-1:0]   r_out_data_q,  w_out_data_d;
    logic            r_gnt_err_q,   w_gnt_err_d;

    // ------------------------------------------------------------------
    // Grant decode. req is derived from registered counts only, so the
    // legality check compares against the un-gated has-data vector; the
    // reset term is folded in separately so nothing pops during reset.
    // ------------------------------------------------------------------
    assign w_multi    = |(gnt & (gnt - 4'd1));
    assign w_onehot   = (gnt != 4'd0) && !w_multi;
    assign w_hit      = |(gnt & w_has_data);
    assign w_grant_ok = !rst && valid && w_onehot && w_hit;
    assign w_bad      = !rst && valid && (w_multi || (w_onehot && !w_hit));

    always_comb begin
        w_idx      = 2'd0;
        w_sel_data = w_head[DW-1:0];
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
                w_idx      = 2'(i);
                w_sel_data = w_head[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-port FIFOs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : g_port
        logic [c_CW-1:0] r_cnt_q,  w_cnt_d;
        logic [c_PW-1:0] r_wptr_q, w_wptr_d;
        logic [c_PW-1:0] r_rptr_q, w_rptr_d;
        logic [DW-1:0]   r_mem_q [DEPTH];
        logic            w_push;
        logic            w_pop;

        assign w_not_full[i]        = (r_cnt_q != c_FULL);
        assign w_has_data[i]        = (r_cnt_q != '0);
        // Push uses the pre-pop count: a full FIFO refuses even while popping.
        assign w_push               = !rst && in_valid[i] && w_not_full[i];
        assign w_pop                = w_grant_ok && gnt[i];
        assign w_head[i*DW +: DW]   = r_mem_q[r_rptr_q];

        always_comb begin
            w_cnt_d  = r_cnt_q;
            w_wptr_d = r_wptr_q;
            w_rptr_d = r_rptr_q;
            if (w_push) begin
                w_wptr_d = r_wptr_q + c_PW'(1);
            end
            if (w_pop) begin
                w_rptr_d = r_rptr_q + c_PW'(1);
            end
            if (w_push && !w_pop) begin
                w_cnt_d = r_cnt_q + c_CW'(1);
            end else if (!w_push && w_pop) begin
                w_cnt_d = r_cnt_q - c_CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt_q  <= '0;
                r_wptr_q <= '0;
                r_rptr_q <= '0;
            end else begin
                r_cnt_q  <= w_cnt_d;
                r_wptr_q <= w_wptr_d;
                r_rptr_q <= w_rptr_d;
            end
        end

        // Storage needs no reset: contents are only visible through counts.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem_q[r_wptr_q] <= in_data[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------
    always_comb begin
        w_out_valid_d = w_grant_ok;
        w_out_port_d  = r_out_port_q;
        w_out_data_d  = r_out_data_q;
        w_gnt_err_d   = r_gnt_err_q | w_bad;
        if (w_grant_ok) begin
            w_out_port_d = w_idx;
            w_out_data_d = w_sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_q <= 1'b0;
            r_out_port_q  <= 2'd0;
            r_out_data_q  <= '0;
            r_gnt_err_q   <= 1'b0;
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_out_port_q  <= w_out_port_d;
            r_out_data_q  <= w_out_data_d;
            r_gnt_err_q   <= w_gnt_err_d;
        end
    end

    assign in_ready  = rst ? 4'd0 : w_not_full;
    assign req       = rst ? 4'd0 : w_has_data;
    assign out_valid = r_out_valid_q;
    assign out_port  = r_out_port_q;
    assign out_data  = r_out_data_q;
    assign gnt_err   = r_gnt_err_q;

endmodule
`default_nettype wire
